nanorisc_multicycle_control: RTL and testbench
==============================================

Name: nanorisc_multicycle_control

Overview:
- Multi-cycle control unit for the NanoRisc core. Replaces the single-cycle opcode decoder with a clocked FSM.
- Sequences fetch, decode, execute, memory and send phases, and handles wait states on memory and the send port.
- Supports a configurable multi-cycle multiplier, resume from halt, and a sticky fault on timeout or illegal opcode.
- Sits between the instruction register and the datapath (PC, register file, ULA, data memory, send port).

Parameters:
- OPCODE_WIDTH, 3, opcode field width; must be >= 3. Opcodes >= 8 are illegal.
- ULAOP_WIDTH, 2, width of ULAOp. Codes: 0 = add, 1 = sub, 2 = mul; upper bits are zero.
- MUL_CYCLES, 3, cycles spent in MULT; must be >= 1.
- WAIT_MAX, 0, maximum wait cycles in MEMRD, MEMWR or SEND before fault; 0 = wait forever.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_ready  in  1  instruction memory data valid.
- opcode  in  OPCODE_WIDTH  opcode from the instruction register; stable from DECODE onward.
- zero  in  1  ULA zero flag, used by bne.
- mem_ready  in  1  data memory access complete.
- send_ready  in  1  send port accepts data.
- resume  in  1  leave HALTED.
- IRWrite  out  1  load the instruction register.
- PCWrite  out  1  update the PC.
- PCSrc  out  1  0 = PC+1, 1 = branch target.
- RegWrite  out  1  register file write from the ULA/send path.
- RegMemWrite  out  1  register file write from memory.
- MemRead  out  1  data memory read request.
- MemWrite  out  1  data memory write request.
- isBranch  out  1  branch instruction executing.
- isSend  out  1  send instruction executing.
- send_valid  out  1  send handshake valid.
- ULAOp  out  ULAOP_WIDTH  ULA operation select.
- halted  out  1  core is in HALTED.
- fault  out  1  sticky fault; cleared only by reset.

Behaviour:
- Reset (asynchronous): state = FETCH, cycle and wait counters = 0, every output = 0 (ULAOp = 0). Reset mid-instruction aborts it with no partial strobes. No output is ever driven to x.
- All strobes are combinational from state plus the qualifying input. Any signal not listed for a state is 0.
- FETCH: wait for imem_ready. In the cycle imem_ready = 1: IRWrite = 1, next state DECODE.
- DECODE: one cycle, no strobes. Next state by opcode:
  - 0 (sum) or 1 (sub) -> EXEC
  - 2 (mul) -> MULT, cycle counter loaded with MUL_CYCLES-1
  - 3 (lwi) -> MEMRD
  - 4 (swi) -> MEMWR
  - 5 (bne) -> BRANCH
  - 6 (halt) -> HALTED
  - 7 (send) -> SEND
  - any opcode >= 8 -> FAULT
- EXEC: ULAOp = opcode (0 or 1), RegWrite = 1, PCWrite = 1 -> FETCH. Instruction latency 3 cycles with immediate imem_ready.
- MULT: ULAOp = 2 held every cycle; counter decrements each cycle. In the cycle counter == 0: RegWrite = 1, PCWrite = 1 -> FETCH. With MUL_CYCLES = 1, MULT behaves like EXEC.
- MEMRD: MemRead = 1 held until mem_ready. In the ready cycle: RegMemWrite = 1, PCWrite = 1 -> FETCH.
- MEMWR: MemWrite = 1 held until mem_ready. In the ready cycle: PCWrite = 1 -> FETCH.
- BRANCH: ULAOp = 1, isBranch = 1, PCWrite = 1, PCSrc = ~zero -> FETCH.
- SEND: isSend = 1, send_valid = 1 held until send_ready. In the handshake cycle: RegWrite = 1, PCWrite = 1 -> FETCH.
- HALTED: halted = 1, all strobes 0. When resume = 1: PCWrite = 1 (PC steps past halt) -> FETCH. resume is ignored in every other state.
- Wait counter:
  - Cleared on entry to MEMRD, MEMWR and SEND; increments each cycle without ready.
  - If WAIT_MAX != 0 and the counter reaches WAIT_MAX with ready still 0 -> FAULT.
  - Ready arriving in the same cycle the counter hits WAIT_MAX wins; the access completes normally.
  - Counter saturates; it never wraps.
- FAULT: fault = 1, all strobes 0, halted = 0. Terminal until reset.
- Exactly one PCWrite pulse per retired instruction. No PCWrite for halt until resume.

Test Plan:
- Reset asserted mid-MULT (MUL_CYCLES=3, counter=1) -> all outputs 0 immediately; after release, IRWrite is the first strobe, not RegWrite.
- sum then mul (MUL_CYCLES=3), imem_ready tied 1 -> sum: RegWrite and PCWrite in cycle 3; mul: ULAOp = 2 for 3 cycles, RegWrite and PCWrite only in the last; total 5 cycles.
- lwi with mem_ready delayed 4 cycles -> MemRead high for 5 cycles; RegMemWrite and PCWrite exactly in the ready cycle.
- bne with zero=0, then bne with zero=1 -> PCSrc = 1 then 0; isBranch = 1 and PCWrite = 1 in both.
- send, send_ready low 2 cycles, WAIT_MAX=2 -> completes (ready wins the tie). Repeat with send_ready never asserted -> fault = 1 after 2 wait cycles; fault stays 1 until reset.
- halt, resume pulsed after 10 cycles -> halted = 1 for 10 cycles with PCWrite = 0; resume cycle gives PCWrite = 1, then FETCH. With OPCODE_WIDTH=4, opcode 9 -> fault = 1.

Source files
------------

// File: rtl/nanorisc_multicycle_control.sv
// NanoRisc multi-cycle control FSM: fetch/decode/execute sequencing with memory and
// send-port wait states, multi-cycle multiply, halt/resume and a sticky fault.
module nanorisc_multicycle_control #(
    parameter int OPCODE_WIDTH = 3,
    parameter int ULAOP_WIDTH  = 2,
    parameter int MUL_CYCLES   = 3,
    parameter int WAIT_MAX     = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    imem_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    input  logic                    send_ready,
    input  logic                    resume,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic                    PCSrc,
    output logic                    RegWrite,
    output logic                    RegMemWrite,
    output logic                    MemRead,
    output logic                    MemWrite,
    output logic                    isBranch,
    output logic                    isSend,
    output logic                    send_valid,
    output logic [ULAOP_WIDTH-1:0]  ULAOp,
    output logic                    halted,
    output logic                    fault
);
    localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam int WW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MULT, S_MEMRD,
        S_MEMWR, S_BRANCH, S_SEND, S_HALTED, S_FAULT
    } state_t;

    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [WW-1:0]   r_wait;
    logic [31:0]     w_op_ext;
    logic            w_wait_state, w_ready, w_timeout;

    assign w_op_ext     = 32'(opcode);
    assign w_wait_state = (r_state == S_MEMRD) || (r_state == S_MEMWR) || (r_state == S_SEND);
    assign w_ready      = (r_state == S_SEND) ? send_ready : mem_ready;
    // A ready arriving in the same cycle the limit is hit still completes the access.
    assign w_timeout    = (WAIT_MAX != 0) && (32'(r_wait) == WAIT_MAX) && !w_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE)
                r_cnt <= CW'(MUL_CYCLES - 1);
            else if (r_state == S_MULT && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (r_state == S_DECODE)
                r_wait <= '0;
            else if (w_wait_state && !w_ready && r_wait != '1)
                r_wait <= r_wait + 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        IRWrite     = 1'b0;
        PCWrite     = 1'b0;
        PCSrc       = 1'b0;
        RegWrite    = 1'b0;
        RegMemWrite = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        isBranch    = 1'b0;
        isSend      = 1'b0;
        send_valid  = 1'b0;
        ULAOp       = '0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (r_state)
            S_FETCH: if (imem_ready) begin
                IRWrite = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                if (w_op_ext > 32'd7) w_next = S_FAULT;
                else case (w_op_ext[2:0])
                    3'd0, 3'd1: w_next = S_EXEC;
                    3'd2:       w_next = S_MULT;
                    3'd3:       w_next = S_MEMRD;
                    3'd4:       w_next = S_MEMWR;
                    3'd5:       w_next = S_BRANCH;
                    3'd6:       w_next = S_HALTED;
                    default:    w_next = S_SEND;
                endcase
            end
            S_EXEC: begin
                ULAOp    = ULAOP_WIDTH'(opcode[0]);
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                w_next   = S_FETCH;
            end
            S_MULT: begin
                ULAOp = ULAOP_WIDTH'(2);
                if (r_cnt == '0) begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                if (mem_ready) begin
                    RegMemWrite = 1'b1;
                    PCWrite     = 1'b1;
                    w_next      = S_FETCH;
                end else if (w_timeout) w_next = S_FAULT;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                if (mem_ready) begin
                    PCWrite = 1'b1;
                    w_next  = S_FETCH;
                end else if (w_timeout) w_next = S_FAULT;
            end
            S_BRANCH: begin
                ULAOp    = ULAOP_WIDTH'(1);
                isBranch = 1'b1;
                PCWrite  = 1'b1;
                PCSrc    = ~zero;
                w_next   = S_FETCH;
            end
            S_SEND: begin
                isSend     = 1'b1;
                send_valid = 1'b1;
                if (send_ready) begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_timeout) w_next = S_FAULT;
            end
            S_HALTED: begin
                halted = 1'b1;
                if (resume) begin
                    PCWrite = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_FAULT: fault = 1'b1;
            default: w_next = S_FETCH;
        endcase
        // Outputs are forced low for the whole reset pulse, not just after the state resets.
        if (reset) begin
            IRWrite     = 1'b0;
            PCWrite     = 1'b0;
            PCSrc       = 1'b0;
            RegWrite    = 1'b0;
            RegMemWrite = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            isBranch    = 1'b0;
            isSend      = 1'b0;
            send_valid  = 1'b0;
            ULAOp       = '0;
            halted      = 1'b0;
            fault       = 1'b0;
        end
    end
endmodule

// File: tb/tb_nanorisc_multicycle_control.sv
// Bench for nanorisc_multicycle_control: instruction-level expectations from a
// procedural model, one bounded-wait instance (WAIT_MAX=2) and one wait-forever instance.
module tb_nanorisc_multicycle_control;
    localparam int MULC = 3;

    localparam logic [13:0] IR = 14'h2000, PCW = 14'h1000, PCS = 14'h0800, RW = 14'h0400,
        RMW = 14'h0200, MR = 14'h0100, MW = 14'h0080, BR = 14'h0040, IS = 14'h0020,
        SV = 14'h0010, HLT = 14'h0002, FLT = 14'h0001;

    logic       clk = 1'b0, rst = 1'b1;
    logic       imem_ready = 1'b0, zero = 1'b0, mem_ready = 1'b0, send_ready = 1'b0, resume = 1'b0;
    logic [3:0] opcode = '0;
    logic       sel = 1'b0;
    int         checks = 0, failures = 0;

    logic       a_ir, a_pcw, a_pcs, a_rw, a_rmw, a_mr, a_mw, a_br, a_is, a_sv, a_h, a_f;
    logic       b_ir, b_pcw, b_pcs, b_rw, b_rmw, b_mr, b_mw, b_br, b_is, b_sv, b_h, b_f;
    logic [1:0] a_ula, b_ula;
    logic [13:0] got_a, got_b;

    always #5 clk = ~clk;

    nanorisc_multicycle_control #(.OPCODE_WIDTH(4), .ULAOP_WIDTH(2), .MUL_CYCLES(MULC), .WAIT_MAX(2)) u_a (
        .clock(clk), .reset(rst), .imem_ready(imem_ready), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .send_ready(send_ready), .resume(resume),
        .IRWrite(a_ir), .PCWrite(a_pcw), .PCSrc(a_pcs), .RegWrite(a_rw), .RegMemWrite(a_rmw),
        .MemRead(a_mr), .MemWrite(a_mw), .isBranch(a_br), .isSend(a_is), .send_valid(a_sv),
        .ULAOp(a_ula), .halted(a_h), .fault(a_f));

    nanorisc_multicycle_control #(.OPCODE_WIDTH(3), .ULAOP_WIDTH(2), .MUL_CYCLES(MULC), .WAIT_MAX(0)) u_b (
        .clock(clk), .reset(rst), .imem_ready(imem_ready), .opcode(opcode[2:0]), .zero(zero),
        .mem_ready(mem_ready), .send_ready(send_ready), .resume(resume),
        .IRWrite(b_ir), .PCWrite(b_pcw), .PCSrc(b_pcs), .RegWrite(b_rw), .RegMemWrite(b_rmw),
        .MemRead(b_mr), .MemWrite(b_mw), .isBranch(b_br), .isSend(b_is), .send_valid(b_sv),
        .ULAOp(b_ula), .halted(b_h), .fault(b_f));

    assign got_a = {a_ir, a_pcw, a_pcs, a_rw, a_rmw, a_mr, a_mw, a_br, a_is, a_sv, a_ula, a_h, a_f};
    assign got_b = {b_ir, b_pcw, b_pcs, b_rw, b_rmw, b_mr, b_mw, b_br, b_is, b_sv, b_ula, b_h, b_f};

    function automatic logic [13:0] ula(input int code);
        return 14'(code) << 2;
    endfunction

    task automatic check(input logic [13:0] exp, input string name);
        logic [13:0] got;
        got = sel ? got_b : got_a;
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut=%0d t=%0t got=%h exp=%h", name, sel, $time, got, exp);
        end
    endtask

    task automatic check_int(input int got, input int exp, input string name);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input logic [13:0] exp, input string name);
        @(negedge clk);
        check(exp, name);
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        zero       = 1'($urandom);
        resume     = 1'($urandom);
        imem_ready = 1'($urandom);
        mem_ready  = 1'($urandom);
        send_ready = 1'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        noise();
        imem_ready = 1'b1;
        #1 check('0, "reset_async");
        @(negedge clk);
        check('0, "reset_hold");
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One instruction from fetch to retirement, expectations built from the instruction rules.
    task automatic run_instr(input int op, input int fw, input int d, input bit z, input int hold,
                             output int ncyc, output bit flt);
        int wmax;
        logic [13:0] base, done;
        bit rdy;
        wmax = sel ? 0 : 2;
        ncyc = 0;
        flt  = 1'b0;
        opcode = 4'(op);
        for (int i = 0; i < fw; i++) begin
            noise(); imem_ready = 1'b0; step('0, "fetch_wait"); ncyc++;
        end
        noise(); imem_ready = 1'b1; step(IR, "fetch"); ncyc++;
        noise(); step('0, "decode"); ncyc++;
        if (op >= 8) flt = 1'b1;
        else case (op)
            0, 1: begin noise(); step(RW | PCW | ula(op), "exec"); ncyc++; end
            2: for (int k = 0; k < MULC; k++) begin
                noise(); step(ula(2) | ((k == MULC - 1) ? (RW | PCW) : 14'h0), "mult"); ncyc++;
            end
            3, 4, 7: begin
                base = (op == 3) ? MR : (op == 4) ? MW : (IS | SV);
                done = (op == 3) ? (RMW | PCW) : (op == 4) ? PCW : (RW | PCW);
                for (int i = 0; i < 80; i++) begin
                    noise();
                    rdy = (i >= d);
                    if (op == 7) send_ready = rdy; else mem_ready = rdy;
                    step(base | (rdy ? done : 14'h0), "wait_access"); ncyc++;
                    if (rdy) break;
                    if (wmax != 0 && i == wmax) begin flt = 1'b1; break; end
                end
            end
            5: begin noise(); zero = z; step(ula(1) | BR | PCW | (z ? 14'h0 : PCS), "branch"); ncyc++; end
            default: begin
                for (int r = 0; r < hold; r++) begin
                    noise(); resume = 1'b0; step(HLT, "halted"); ncyc++;
                end
                noise(); resume = 1'b1; step(HLT | PCW, "resume"); ncyc++;
            end
        endcase
        if (flt) for (int k = 0; k < 4; k++) begin
            noise(); step(FLT, "fault_sticky");
        end
    endtask

    typedef struct {
        bit sel; int op; int fw; int d; bit z; int hold;
        int exp_cyc; bit exp_flt;
    } vec_t;

    vec_t vecs[$];
    int   ncyc;
    bit   flt, prev_sel;

    initial begin
        vecs.push_back('{0, 0, 0, 0, 0, 0,  3, 0});  // sum
        vecs.push_back('{0, 2, 0, 0, 0, 0,  5, 0});  // mul
        vecs.push_back('{1, 3, 0, 4, 0, 0,  7, 0});  // lwi, 4 wait cycles, unlimited wait
        vecs.push_back('{0, 4, 1, 1, 0, 0,  5, 0});  // swi
        vecs.push_back('{0, 5, 0, 0, 0, 0,  3, 0});  // bne taken
        vecs.push_back('{0, 5, 0, 0, 1, 0,  3, 0});  // bne not taken
        vecs.push_back('{0, 7, 0, 2, 0, 0,  5, 0});  // send, ready on the limit cycle
        vecs.push_back('{0, 7, 0, 99, 0, 0, 5, 1});  // send, never ready
        vecs.push_back('{0, 6, 0, 0, 0, 10, 13, 0}); // halt, resume after 10
        vecs.push_back('{0, 9, 0, 0, 0, 0,  2, 1});  // illegal opcode
        vecs.push_back('{0, 3, 0, 3, 0, 0,  5, 1});  // lwi timeout
        vecs.push_back('{1, 7, 2, 6, 0, 0, 11, 0});  // send, long wait, unlimited

        #2;
        do_reset();

        // Reset in the middle of a multiply aborts it; the next strobe is IRWrite.
        opcode = 4'd2;
        noise(); imem_ready = 1'b1; step(IR, "mm_fetch");
        noise(); step('0, "mm_decode");
        noise(); step(ula(2), "mm_mult0");
        rst = 1'b1;
        #1 check('0, "reset_mid_mult");
        @(negedge clk); check('0, "reset_mid_mult_hold");
        @(posedge clk); #1 rst = 1'b0;
        opcode = 4'd0;
        noise(); imem_ready = 1'b1; step(IR, "post_reset_fetch");
        noise(); step('0, "post_reset_decode");
        noise(); step(RW | PCW, "post_reset_exec");

        prev_sel = 1'b0;
        foreach (vecs[i]) begin
            sel = vecs[i].sel;
            if (sel != prev_sel) do_reset();
            prev_sel = sel;
            run_instr(vecs[i].op, vecs[i].fw, vecs[i].d, vecs[i].z, vecs[i].hold, ncyc, flt);
            check_int(ncyc, vecs[i].exp_cyc, "vec_cycles");
            check_int(int'(flt), int'(vecs[i].exp_flt), "vec_fault");
            if (flt) do_reset();
        end

        for (int n = 0; n < 300; n++) begin
            sel = 1'($urandom);
            if (sel != prev_sel) do_reset();
            prev_sel = sel;
            run_instr(sel ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 9)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom), int'($urandom_range(0, 3)), ncyc, flt);
            if (flt) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
